// File: rtl/store_lane_packer.sv
// Store-path lane packer: turns a byte/half/word store into word-aligned bus beats with byte enables.
// Define STORE_SPLIT_EN to split word-straddling stores into two beats; otherwise they are dropped with fmt_err.
module store_lane_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic        busy,
  output logic        fmt_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1
`ifdef STORE_SPLIT_EN
    ,
    BEAT1 = 2'd2
`endif
  } state_t;

  state_t      state_r;
  logic [1:0]  off_s;
  logic [31:0] base_s;
  logic [31:0] val_s;
  logic [3:0]  be_mask_s;
  logic        size_ok_s;
  logic [7:0]  be_full_s;
  logic [31:0] lo_data_s;
  logic        split_need_s;
  logic        good_s;
  logic        last_beat_s;
  logic        accept_s;

`ifdef STORE_SPLIT_EN
  logic        split_r;
  logic [31:0] hi_addr_r;
  logic [31:0] hi_data_r;
  logic [3:0]  hi_be_r;
  logic [31:0] hi_addr_s;
  logic [31:0] hi_data_s;
`endif

  assign off_s  = req_addr[1:0];
  assign base_s = {req_addr[31:2], 2'b00};

  // Select the live bytes of the store value and their unshifted lane mask.
  always_comb begin
    val_s     = 32'd0;
    be_mask_s = 4'b0000;
    size_ok_s = 1'b0;
    case (req_size)
      2'b00: begin
        val_s     = {24'd0, req_wdata[7:0]};
        be_mask_s = 4'b0001;
        size_ok_s = 1'b1;
      end
      2'b01: begin
        val_s     = {16'd0, req_wdata[15:0]};
        be_mask_s = 4'b0011;
        size_ok_s = 1'b1;
      end
      2'b10: begin
        val_s     = req_wdata;
        be_mask_s = 4'b1111;
        size_ok_s = 1'b1;
      end
      default: begin
        val_s     = 32'd0;
        be_mask_s = 4'b0000;
        size_ok_s = 1'b0;
      end
    endcase
  end

  // Upper nibble of the 8-lane enable marks bytes that spill into the next word.
  assign be_full_s    = {4'b0000, be_mask_s} << off_s;
  assign lo_data_s    = val_s << {off_s, 3'b000};
  assign split_need_s = |be_full_s[7:4];

`ifdef STORE_SPLIT_EN
  assign hi_data_s   = val_s >> (6'd32 - {1'b0, off_s, 3'b000});
  assign hi_addr_s   = base_s + 32'd4;
  assign good_s      = size_ok_s;
  assign last_beat_s = ((state_r == BEAT0) && !split_r) || (state_r == BEAT1);
`else
  assign good_s      = size_ok_s && !split_need_s;
  assign last_beat_s = (state_r == BEAT0);
`endif

  assign req_ready = !rst && ((state_r == IDLE) || (last_beat_s && bus_valid && bus_ready));
  assign accept_s  = req_valid && req_ready;

  // Beat sequencer: loads a request on accept, steps to the high beat or retires on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      bus_valid <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_be    <= 4'b0000;
      fmt_err   <= 1'b0;
`ifdef STORE_SPLIT_EN
      split_r   <= 1'b0;
      hi_addr_r <= 32'd0;
      hi_data_r <= 32'd0;
      hi_be_r   <= 4'b0000;
`endif
    end else begin
      fmt_err <= accept_s && !good_s;
      if (accept_s && good_s) begin
        state_r   <= BEAT0;
        busy      <= 1'b1;
        bus_valid <= 1'b1;
        bus_addr  <= base_s;
        bus_wdata <= lo_data_s;
        bus_be    <= be_full_s[3:0];
`ifdef STORE_SPLIT_EN
        split_r   <= split_need_s;
        hi_addr_r <= hi_addr_s;
        hi_data_r <= hi_data_s;
        hi_be_r   <= be_full_s[7:4];
`endif
      end else if (bus_valid && bus_ready) begin
`ifdef STORE_SPLIT_EN
        if ((state_r == BEAT0) && split_r) begin
          state_r   <= BEAT1;
          bus_addr  <= hi_addr_r;
          bus_wdata <= hi_data_r;
          bus_be    <= hi_be_r;
        end else begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          bus_valid <= 1'b0;
        end
`else
        state_r   <= IDLE;
        busy      <= 1'b0;
        bus_valid <= 1'b0;
`endif
      end
    end
  end

endmodule
